// File: rtl/uart_byte_rx_if.sv
// Byte-side bundle of the UART receiver: serial line in, byte/valid/error/busy out.
// master = receiver, slave = line driver plus byte consumer.
interface uart_byte_rx_if;
    logic       RX;
    logic       RX_vld;
    logic [7:0] RXData;
    logic       frame_err;
    logic       busy;

    modport master (
        input  RX,
        output RX_vld,
        output RXData,
        output frame_err,
        output busy
    );

    modport slave (
        output RX,
        input  RX_vld,
        input  RXData,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver: 2-flop sync, start detect, mid-bit sampling, stop check.
// Latency 2+HALF+9*CYC+1 clocks from start edge; no backpressure, byte must be taken within 10 bit times.
module uart_byte_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic           CLK,
    input  logic           RST,
    uart_byte_rx_if.master bus
);

    localparam int CYC  = CLK_FREQ / BAUD;
    localparam int HALF = CYC / 2;
    localparam int TW   = $clog2(CYC);
    localparam logic [TW-1:0] TMR_LAST  = TW'(CYC - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic          rx_m, rx_s;
    logic [TW-1:0] bit_tmr, tmr_nxt;
    logic [2:0]    bit_idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    rx_data, data_nxt;
    logic          rx_vld, vld_nxt;
    logic          err, err_nxt;

    // Synchroniser resets to the idle-high line level so reset release is not a start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.RX;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            bit_tmr <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rx_data <= '0;
            rx_vld  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_tmr <= tmr_nxt;
            bit_idx <= idx_nxt;
            shift   <= shift_nxt;
            rx_data <= data_nxt;
            rx_vld  <= vld_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = bit_tmr + TW'(1);
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        data_nxt  = rx_data;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (bit_tmr == HALF_LAST) begin
                    tmr_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tmr == TMR_LAST) begin
                    tmr_nxt   = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 idx_nxt   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_tmr == TMR_LAST) begin
                    tmr_nxt = '0;
                    if (rx_s) begin
                        vld_nxt   = 1'b1;
                        data_nxt  = shift;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must return high before a new start is accepted.
                tmr_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                tmr_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.RX_vld    = rx_vld;
    assign bus.RXData    = rx_data;
    assign bus.frame_err = err;
    assign bus.busy      = (state != IDLE);

endmodule
